rr_port_arbiter: RTL and testbench

RR_PORT_ARBITER -- requirements
Module: rr_port_arbiter

---
 rtl/switch_defs.sv | 19 +
 rtl/rr_port_arbiter_if.sv | 26 ++
 rtl/rr_picker.sv | 30 +++
 rtl/rr_port_arbiter.sv | 98 +++++++++
 tb/tb_rr_port_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/switch_defs.sv
// Shared switch types: packet format, port geometry and the arbiter FSM state.
package switch_defs;

  localparam int PORT_W    = 2;
  localparam int NUM_PORTS = 4;
  localparam int DATA_W    = 14;
  localparam int CNT_W     = 16;

  typedef struct packed {
    logic [PORT_W-1:0] dst;
    logic [DATA_W-1:0] payload;
  } packet_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_port_arbiter_if.sv
// Bundle between the input FIFOs, one output-port arbiter and its downstream sink.
interface rr_port_arbiter_if
  import switch_defs::*;
#(
  parameter int NUM_IN = 4
);

  logic [NUM_IN-1:0]          fifo_empty;
  packet_t [NUM_IN-1:0]       fifo_head;
  logic [NUM_IN-1:0]          fifo_pop;
  packet_t                    out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [PORT_W-1:0]          grant_id;

  modport master (
    input  fifo_empty, fifo_head, out_ready,
    output fifo_pop, out_data, out_valid, grant_id
  );

  modport slave (
    output fifo_empty, fifo_head, out_ready,
    input  fifo_pop, out_data, out_valid, grant_id
  );

endinterface

// File: rtl/rr_picker.sv
// Round-robin priority picker: first asserted request at or after ptr, wrapping.
module rr_picker #(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic              gnt_valid
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_IN);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign gnt_valid = |req;

endmodule

// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter feeding one output port from NUM_IN input FIFOs.
// Optional per-input grant counters are built when ARB_STATS_EN is defined.
module rr_port_arbiter
  import switch_defs::*;
#(
  parameter int PORT_ID = 0,
  parameter int NUM_IN  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_port_arbiter_if.master  bus
`ifdef ARB_STATS_EN
  ,
  input  logic                         stats_clr,
  output logic [NUM_IN-1:0][CNT_W-1:0] grant_cnt
`endif
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  arb_state_e        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  next_ptr;
  logic [NUM_IN-1:0] eligible;
  logic [NUM_IN-1:0] gnt;
  logic              gnt_valid;
  logic              load_opp;
  logic              grant;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_IN; i++)
      eligible[i] = !bus.fifo_empty[i] && (bus.fifo_head[i].dst == PORT_W'(PORT_ID));
  end

  rr_picker #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req       (eligible),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  // Output register is free when idle or when its packet leaves this cycle.
  assign load_opp     = (state == ST_IDLE) || bus.out_ready;
  assign grant        = rst_n && load_opp && gnt_valid;
  assign bus.fifo_pop = grant ? gnt : '0;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (gnt[i]) win_idx = IDX_W'(i);
  end

  assign next_ptr = (win_idx == IDX_W'(NUM_IN - 1)) ? '0 : win_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bus.out_data <= '0;
      bus.grant_id <= '0;
      rr_ptr       <= '0;
    end else if (load_opp) begin
      if (grant) begin
        state        <= ST_SEND;
        bus.out_data <= bus.fifo_head[win_idx];
        bus.grant_id <= PORT_W'(win_idx);
        rr_ptr       <= next_ptr;
      end else begin
        state        <= ST_IDLE;
      end
    end
  end

  assign bus.out_valid = (state == ST_SEND);

`ifdef ARB_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Clear dominates a grant landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (stats_clr) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++)
        if (bus.fifo_pop[i]) grant_cnt[i] <= sat_inc(grant_cnt[i]);
    end
  end
`endif

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Directed and randomized check of rr_port_arbiter against a queue-free reference model.
module tb_rr_port_arbiter;
  import switch_defs::*;

  localparam int NI  = 4;
  localparam int PID = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_port_arbiter_if #(.NUM_IN(NI)) bus();

`ifdef ARB_STATS_EN
  logic                 stats_clr;
  logic [NI-1:0][15:0]  grant_cnt;
`endif

  rr_port_arbiter #(
    .PORT_ID (PID),
    .NUM_IN  (NI)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: what the output register should hold and where the search starts.
  bit      m_valid;
  packet_t m_data;
  int      m_gid;
  int      m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_gid   = 0;
    m_ptr   = 0;
  endtask

  function automatic bit elig(input int i);
    return (bus.fifo_empty[i] == 1'b0) && (int'(bus.fifo_head[i].dst) == PID);
  endfunction

  function automatic int model_winner();
    if (m_valid && !bus.out_ready) return -1;
    for (int k = 0; k < NI; k++)
      if (elig((m_ptr + k) % NI)) return (m_ptr + k) % NI;
    return -1;
  endfunction

  task automatic put(input int i, input bit empty, input int dst, input int pl);
    bus.fifo_empty[i]         = empty;
    bus.fifo_head[i].dst      = PORT_W'(dst);
    bus.fifo_head[i].payload  = DATA_W'(pl);
  endtask

  // Called at a falling edge with inputs settled; checks, advances one cycle, returns at next falling edge.
  task automatic tick(input string tag);
    int          w;
    logic [3:0]  exp_pop;
    packet_t     cap;
    #1;
    w = model_winner();
    exp_pop = (w < 0) ? 4'b0000 : (4'b0001 << w);
    cap = (w < 0) ? packet_t'(0) : bus.fifo_head[w];
    check({tag, ".pop"}, 32'(bus.fifo_pop), 32'(exp_pop));
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      check({tag, ".data"}, 32'(bus.out_data), 32'(m_data));
      check({tag, ".gid"}, 32'(bus.grant_id), 32'(m_gid));
    end
    @(posedge clk);
    if (!m_valid || bus.out_ready) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = cap;
        m_gid   = w;
        m_ptr   = (w + 1) % NI;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, ".rst_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".rst_data"}, 32'(bus.out_data), 32'd0);
    check({tag, ".rst_gid"}, 32'(bus.grant_id), 32'd0);
    check({tag, ".rst_pop"}, 32'(bus.fifo_pop), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    packet_t saved;
    bus.fifo_empty = '1;
    bus.fifo_head  = '0;
    bus.out_ready  = 1'b1;
`ifdef ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    model_reset();
    @(negedge clk);

    // Reset with an eligible input present: nothing may be popped.
    put(1, 1'b0, PID, 14'h0AA);
    do_reset("init");

    // Single request from input 1.
    bus.fifo_empty = 4'b1101;
    put(1, 1'b0, PID, 14'h123);
    #1 check("single.pop_direct", 32'(bus.fifo_pop), 32'h2);
    tick("single");
    check("single.valid_direct", 32'(bus.out_valid), 32'd1);
    check("single.gid_direct", 32'(bus.grant_id), 32'd1);
    bus.fifo_empty = '1;
    tick("drain");
    tick("idle");

    // Fairness: everyone eligible, sink always ready.
    do_reset("fair");
    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < NI; i++) put(i, 1'b0, PID, int'($urandom_range(0, 16383)));
      tick("fair");
      check("fair.gid_seq", 32'(bus.grant_id), 32'(j % NI));
      check("fair.no_gap", 32'(bus.out_valid), 32'd1);
    end

    // Backpressure while holding a packet.
    saved = bus.out_data;
    bus.out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick("bp");
      check("bp.data_hold", 32'(bus.out_data), 32'(saved));
      #1 check("bp.pop_zero", 32'(bus.fifo_pop), 32'd0);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1 check("bp.release_pop", 32'(|bus.fifo_pop), 32'd1);
    tick("bp_release");

    // Destination filter: the only non-empty head targets another port.
    do_reset("filt");
    bus.fifo_empty = 4'b1110;
    put(0, 1'b0, 3, 14'h3FF);
    for (int j = 0; j < 4; j++) begin
      tick("filt");
      check("filt.pop0", 32'(bus.fifo_pop[0]), 32'd0);
      check("filt.valid", 32'(bus.out_valid), 32'd0);
    end

    // Reset while a packet is held; pointer restarts at 0.
    for (int i = 0; i < NI; i++) put(i, 1'b0, PID, 14'h100 + i);
    tick("pre_rst");
    tick("pre_rst");
    check("midrst.valid_before", 32'(bus.out_valid), 32'd1);
    do_reset("midrst");
    #1 check("midrst.first_pop", 32'(bus.fifo_pop), 32'h1);
    tick("post_rst");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NI; i++)
        put(i, $urandom_range(0, 2) == 0, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : PID,
            int'($urandom_range(0, 16383)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick("rand");
    end

`ifdef ARB_STATS_EN
    do_reset("stats");
    bus.out_ready  = 1'b1;
    bus.fifo_empty = 4'b1011;
    put(2, 1'b0, PID, 14'h222);
    repeat (70000) @(negedge clk);
    check("stats.sat", 32'(grant_cnt[2]), 32'hFFFF);
    check("stats.other", 32'(grant_cnt[0]), 32'd0);
    stats_clr = 1'b1;
    #1 check("stats.clr_pop", 32'(bus.fifo_pop), 32'h4);
    @(negedge clk);
    stats_clr = 1'b0;
    check("stats.clr_wins", 32'(grant_cnt[2]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
